fp_addsub_pipe: RTL

Parametrised, three-stage pipelined IEEE-754-style floating-point adder/subtractor with valid/ready handshaking on both sides. It replaces the single-cycle half-precision adder in the datapath, adding subtraction, round-to-nearest-even, special-value handling and exception flags. Default parameters give binary16. The block sits between the register-file read stage and the writeback mux of the FP unit.

---
 rtl/fp_addsub_pipe.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fp_addsub_pipe.sv
// Three-stage pipelined floating-point adder/subtractor: unpack/align, add, normalize/round.
// Subnormals flush to zero, rounding is nearest-even, and one enable stalls the whole pipe on backpressure.
module fp_addsub_pipe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 op_sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [3:0]           flags
);

    localparam int W       = 1 + EXP_W + MAN_W;
    localparam int SIGX_W  = MAN_W + 1;
    localparam int SIGY_W  = MAN_W + 4;
    localparam int SUM_W   = MAN_W + 5;
    localparam int NORM_W  = MAN_W + 4;
    localparam int SH_MAX  = MAN_W + 3;
    localparam int SHW     = $clog2(SH_MAX + 1);
    localparam int LZW     = $clog2(SUM_W);
    localparam int EW      = EXP_W + LZW + 2;
    localparam int EXP_MAX = (1 << EXP_W) - 1;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // ---------------- stage 1: unpack, classify, swap, align ----------------
    logic                 sa, sb;
    logic [EXP_W-1:0]     ea, eb;
    logic [MAN_W-1:0]     fa, fb, fa_f, fb_f;
    logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
    logic                 swap;

    assign sa     = a[W-1];
    assign sb     = b[W-1] ^ op_sub;
    assign ea     = a[W-2:MAN_W];
    assign eb     = b[W-2:MAN_W];
    assign fa     = a[MAN_W-1:0];
    assign fb     = b[MAN_W-1:0];
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (&ea) && (fa == '0);
    assign b_inf  = (&eb) && (fb == '0);
    assign a_nan  = (&ea) && (fa != '0);
    assign b_nan  = (&eb) && (fb != '0);
    assign a_snan = a_nan && !fa[MAN_W-1];
    assign b_snan = b_nan && !fb[MAN_W-1];
    assign fa_f   = a_zero ? '0 : fa;
    assign fb_f   = b_zero ? '0 : fb;
    assign swap   = {eb, fb_f} > {ea, fa_f};

    logic                 sx_d, eff_sub_d;
    logic [EXP_W-1:0]     ex_d, ey, exp_diff;
    logic [SIGX_W-1:0]    sigx_d, sigy;
    logic [SHW-1:0]       sh_amt;
    logic [SIGY_W-1:0]    y_ext, y_shr, y_align_d;
    logic                 y_lost;

    always_comb begin
        sx_d      = swap ? sb : sa;
        eff_sub_d = sa ^ sb;
        ex_d      = swap ? eb : ea;
        ey        = swap ? ea : eb;
        sigx_d    = swap ? {~b_zero, fb_f} : {~a_zero, fa_f};
        sigy      = swap ? {~a_zero, fa_f} : {~b_zero, fb_f};
        exp_diff  = ex_d - ey;
        sh_amt    = (int'(exp_diff) > SH_MAX) ? SHW'(SH_MAX) : SHW'(exp_diff);
        y_ext     = {sigy, 3'b000};
        y_shr     = y_ext >> sh_amt;
        // bits pushed past the sticky position are folded back into it
        y_lost    = |(y_ext & ~({SIGY_W{1'b1}} << sh_amt));
        y_align_d = {y_shr[SIGY_W-1:1], y_shr[0] | y_lost};
    end

    logic                 spec1_d, spec1_inv_d;
    logic [W-1:0]         spec1_res_d;

    always_comb begin
        spec1_d     = 1'b1;
        spec1_inv_d = 1'b0;
        spec1_res_d = '0;
        if (a_nan || b_nan) begin
            spec1_res_d = QNAN;
            spec1_inv_d = a_snan || b_snan;
        end else if (a_inf && b_inf && (sa != sb)) begin
            spec1_res_d = QNAN;
            spec1_inv_d = 1'b1;
        end else if (a_inf) begin
            spec1_res_d = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            spec1_res_d = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (a_zero && b_zero) begin
            // only -0 combined with an effective -0 keeps the negative sign
            spec1_res_d = {sa & sb, {(W-1){1'b0}}};
        end else begin
            spec1_d = 1'b0;
        end
    end

    logic                 s1_valid_q, s1_sign_q, s1_sub_q, s1_spec_q, s1_inv_q;
    logic [EXP_W-1:0]     s1_exp_q;
    logic [SIGX_W-1:0]    s1_sigx_q;
    logic [SIGY_W-1:0]    s1_sigy_q;
    logic [W-1:0]         s1_spec_res_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q    <= 1'b0;
            s1_sign_q     <= 1'b0;
            s1_sub_q      <= 1'b0;
            s1_spec_q     <= 1'b0;
            s1_inv_q      <= 1'b0;
            s1_exp_q      <= '0;
            s1_sigx_q     <= '0;
            s1_sigy_q     <= '0;
            s1_spec_res_q <= '0;
        end else if (en) begin
            s1_valid_q    <= in_valid;
            s1_sign_q     <= sx_d;
            s1_sub_q      <= eff_sub_d;
            s1_spec_q     <= spec1_d;
            s1_inv_q      <= spec1_inv_d;
            s1_exp_q      <= ex_d;
            s1_sigx_q     <= sigx_d;
            s1_sigy_q     <= y_align_d;
            s1_spec_res_q <= spec1_res_d;
        end
    end

    // ---------------- stage 2: significand add/subtract ----------------
    logic [SUM_W-1:0]     x_add, y_add, sum_d;

    always_comb begin
        x_add = {1'b0, s1_sigx_q, 3'b000};
        y_add = {1'b0, s1_sigy_q};
        sum_d = s1_sub_q ? (x_add - y_add) : (x_add + y_add);
    end

    logic                 s2_valid_q, s2_sign_q, s2_spec_q, s2_inv_q;
    logic [EXP_W-1:0]     s2_exp_q;
    logic [SUM_W-1:0]     s2_sum_q;
    logic [W-1:0]         s2_spec_res_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q    <= 1'b0;
            s2_sign_q     <= 1'b0;
            s2_spec_q     <= 1'b0;
            s2_inv_q      <= 1'b0;
            s2_exp_q      <= '0;
            s2_sum_q      <= '0;
            s2_spec_res_q <= '0;
        end else if (en) begin
            s2_valid_q    <= s1_valid_q;
            s2_sign_q     <= s1_sign_q;
            s2_spec_q     <= s1_spec_q;
            s2_inv_q      <= s1_inv_q;
            s2_exp_q      <= s1_exp_q;
            s2_sum_q      <= sum_d;
            s2_spec_res_q <= s1_spec_res_q;
        end
    end

    // ---------------- stage 3: normalize, round, exceptions ----------------
    function automatic logic [LZW-1:0] lzc(input logic [SUM_W-2:0] v);
        logic [LZW-1:0] cnt;
        cnt = LZW'(SUM_W - 1);
        for (int i = 0; i < SUM_W - 1; i++) begin
            if (v[i]) cnt = LZW'(SUM_W - 2 - i);
        end
        return cnt;
    endfunction

    logic [LZW-1:0]       lz;
    logic [NORM_W-1:0]    norm;
    logic signed [EW-1:0] exp_n, exp_r;
    logic                 rnd_up, inexact;
    logic [MAN_W+1:0]     mant;
    logic [MAN_W-1:0]     frac_r;
    logic [W-1:0]         result_d;
    logic [3:0]           flags_d;

    always_comb begin
        lz = lzc(s2_sum_q[SUM_W-2:0]);
        if (s2_sum_q[SUM_W-1]) begin
            norm  = {s2_sum_q[SUM_W-1:2], s2_sum_q[1] | s2_sum_q[0]};
            exp_n = EW'({2'b00, s2_exp_q}) + EW'(1);
        end else begin
            norm  = s2_sum_q[SUM_W-2:0] << lz;
            exp_n = EW'({2'b00, s2_exp_q}) - EW'(lz);
        end
        inexact = |norm[2:0];
        rnd_up  = norm[2] && (norm[1] || norm[0] || norm[3]);
        mant    = {1'b0, norm[NORM_W-1:3]} + {{(MAN_W+1){1'b0}}, rnd_up};
        exp_r   = exp_n + EW'(mant[MAN_W+1]);
        frac_r  = mant[MAN_W+1] ? mant[MAN_W:1] : mant[MAN_W-1:0];

        result_d = {s2_sign_q, exp_r[EXP_W-1:0], frac_r};
        flags_d  = {3'b000, inexact};
        if (s2_spec_q) begin
            result_d = s2_spec_res_q;
            flags_d  = {s2_inv_q, 3'b000};
        end else if (s2_sum_q == '0) begin
            result_d = '0;
            flags_d  = 4'b0000;
        end else if (int'(exp_n) <= 0) begin
            result_d = {s2_sign_q, {(W-1){1'b0}}};
            flags_d  = 4'b0011;
        end else if (int'(exp_r) >= EXP_MAX) begin
            result_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_d  = 4'b0101;
        end
    end

    logic                 out_valid_q;
    logic [W-1:0]         result_q;
    logic [3:0]           flags_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else if (en) begin
            out_valid_q <= s2_valid_q;
            result_q    <= result_d;
            flags_q     <= flags_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

endmodule
